// File: rtl/ysyx_22041207_ifu_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel,
// decoder valid/ready channel, and the back-end redirect/trap controls.
// The IFU side uses the master modport; memory/decoder/back-end use slave.
interface ysyx_22041207_ifu_if;

  // instruction memory channel
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // decoder channel
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;

  // control-flow changes resolved downstream
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        trap_enter;
  logic [63:0] mtvec;
  logic        trap_ret;
  logic [63:0] mepc;

  // statistics
  logic [63:0] fetch_cnt;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready,
    input  redirect_valid,
    input  redirect_pc,
    input  trap_enter,
    input  mtvec,
    input  trap_ret,
    input  mepc,
    output fetch_cnt
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready,
    output redirect_valid,
    output redirect_pc,
    output trap_enter,
    output mtvec,
    output trap_ret,
    output mepc,
    input  fetch_cnt
  );

endinterface

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns the architectural PC, keeps at most one
// instruction-memory request in flight, and hands each returned word to
// the decoder over valid/ready. Any flush (trap entry, mret or resolved
// jump/branch) retargets the PC; a fetch already granted on the wrong
// path is marked with drop and its response is thrown away.
module ysyx_22041207_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_22041207_ifu_if.master       bus
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t      state_reg,   state_next;
  logic [63:0] pc_reg,      pc_next;
  logic        drop_reg,    drop_next;
  logic        req_reg,     req_next;
  logic        valid_reg,   valid_next;
  logic [31:0] inst_reg,    inst_next;
  logic [63:0] inst_pc_reg, inst_pc_next;
  logic [63:0] cnt_reg,     cnt_next;

  logic        flush;
  logic [63:0] target_raw;
  logic [63:0] target;

  // Flush target: trap entry beats mret beats redirect; always word-aligned.
  always_comb begin
    flush = bus.trap_enter | bus.trap_ret | bus.redirect_valid;
    if (bus.trap_enter) begin
      target_raw = bus.mtvec;
    end else if (bus.trap_ret) begin
      target_raw = bus.mepc;
    end else begin
      target_raw = bus.redirect_pc;
    end
    target = {target_raw[63:2], 2'b00};
  end

  // Next-state and next-register logic for the fetch FSM.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    drop_next    = drop_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    cnt_next     = cnt_reg;

    case (state_reg)
      ST_RST: begin
        // Leave reset unconditionally; the first fetch is RESET_PC.
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (flush) begin
          pc_next = target;
        end
        if (bus.imem_gnt) begin
          // A request granted alongside a flush fetched the old path.
          state_next = ST_WAIT;
          drop_next  = flush;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          pc_next = target;
        end
        if (bus.imem_rvalid) begin
          if (drop_reg || flush) begin
            drop_next  = 1'b0;
            state_next = ST_FETCH;
          end else begin
            inst_next    = bus.imem_rdata;
            inst_pc_next = pc_reg;
            state_next   = ST_HOLD;
          end
        end else if (flush) begin
          // Response still pending: remember to discard it when it lands.
          drop_next = 1'b1;
        end
      end

      ST_HOLD: begin
        if (flush) begin
          // A handshake coinciding with a flush is void: no pc/count step.
          pc_next    = target;
          state_next = ST_FETCH;
        end else if (bus.inst_ready) begin
          pc_next    = pc_reg + 64'd4;
          cnt_next   = cnt_reg + 64'd1;
          state_next = ST_FETCH;
        end
      end

      default: begin
        state_next = ST_RST;
      end
    endcase

    // Request and valid are registered decodes of the upcoming state.
    req_next   = (state_next == ST_FETCH);
    valid_next = (state_next == ST_HOLD);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_RST;
      pc_reg      <= RESET_PC;
      drop_reg    <= 1'b0;
      req_reg     <= 1'b0;
      valid_reg   <= 1'b0;
      inst_reg    <= 32'h0;
      inst_pc_reg <= 64'h0;
      cnt_reg     <= 64'h0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      drop_reg    <= drop_next;
      req_reg     <= req_next;
      valid_reg   <= valid_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign bus.imem_req   = req_reg;
  assign bus.imem_addr  = pc_reg;
  assign bus.inst_valid = valid_reg;
  assign bus.inst       = inst_reg;
  assign bus.inst_pc    = inst_pc_reg;
  assign bus.fetch_cnt  = cnt_reg;

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Directed bench for the fetch unit. Memory, decoder and back-end are
// driven cycle by cycle from scripted tasks; outputs are sampled 1 time
// unit after each rising edge, and inputs are changed at the same point.
module tb_ysyx_22041207_ifu;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ysyx_22041207_ifu_if bus();

  ysyx_22041207_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b want=0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL reset_addr got=%h want=8000_0000", bus.imem_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", bus.inst_valid); end
    n_cmp++; if (bus.inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got=%h want=0", bus.inst); end
    n_cmp++; if (bus.inst_pc !== 64'h0) begin n_err++; $display("FAIL reset_inst_pc got=%h want=0", bus.inst_pc); end
    n_cmp++; if (bus.fetch_cnt !== 64'h0) begin n_err++; $display("FAIL reset_cnt got=%0d want=0", bus.fetch_cnt); end
    $display("reset: outputs checked while rst held");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    // cycle 1: request to RESET_PC, granted at once
    step();
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req1 got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL basic_addr1 got=%h want=8000_0000", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    // cycle 2: in WAIT, memory responds
    step();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req2 got=%0b want=0", bus.imem_req); end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    // cycle 3: instruction presented
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0b want=1", bus.inst_valid); end
    n_cmp++; if (bus.inst !== 32'h0000_0013) begin n_err++; $display("FAIL basic_inst got=%h want=00000013", bus.inst); end
    n_cmp++; if (bus.inst_pc !== 64'h8000_0000) begin n_err++; $display("FAIL basic_inst_pc got=%h want=8000_0000", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop got=%0b want=0", bus.inst_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req4 got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0004) begin n_err++; $display("FAIL basic_next_addr got=%h want=8000_0004", bus.imem_addr); end
    n_cmp++; if (bus.fetch_cnt !== 64'd1) begin n_err++; $display("FAIL basic_cnt got=%0d want=1", bus.fetch_cnt); end
    $display("basic: fetched 0x80000000, next request 0x%h cnt=%0d", bus.imem_addr, bus.fetch_cnt);
  endtask

  task automatic test_stall();
    // memory withholds the grant for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d] got=%0b want=1", i, bus.imem_req); end
      n_cmp++; if (bus.imem_addr !== 64'h8000_0004) begin n_err++; $display("FAIL stall_addr[%0d] got=%h want=8000_0004", i, bus.imem_addr); end
    end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0010_0093;
    step();
    bus.imem_rvalid = 1'b0;
    // decoder withholds ready for 4 cycles
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%0b want=1", i, bus.inst_valid); end
      n_cmp++; if (bus.inst !== 32'h0010_0093) begin n_err++; $display("FAIL stall_inst[%0d] got=%h want=00100093", i, bus.inst); end
      n_cmp++; if (bus.inst_pc !== 64'h8000_0004) begin n_err++; $display("FAIL stall_inst_pc[%0d] got=%h want=8000_0004", i, bus.inst_pc); end
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_noreq[%0d] got=%0b want=0", i, bus.imem_req); end
      step();
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    n_cmp++; if (bus.fetch_cnt !== 64'd2) begin n_err++; $display("FAIL stall_cnt got=%0d want=2", bus.fetch_cnt); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0008) begin n_err++; $display("FAIL stall_next_addr got=%h want=8000_0008", bus.imem_addr); end
    $display("stall: held request and instruction, next request 0x%h", bus.imem_addr);
  endtask

  task automatic test_redirect_wait();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0103;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_noreq got=%0b want=0", bus.imem_req); end
    step();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_noreq2 got=%0b want=0", bus.imem_req); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hdead_beef;
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got=%0b want=0", bus.inst_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL redir_req got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0100) begin n_err++; $display("FAIL redir_addr got=%h want=8000_0100", bus.imem_addr); end
    n_cmp++; if (bus.fetch_cnt !== 64'd2) begin n_err++; $display("FAIL redir_cnt got=%0d want=2", bus.fetch_cnt); end
    $display("redirect_wait: stale response dropped, request 0x%h", bus.imem_addr);
  endtask

  task automatic test_flush_hold();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0073;
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL fhold_valid got=%0b want=1", bus.inst_valid); end
    n_cmp++; if (bus.inst_pc !== 64'h8000_0100) begin n_err++; $display("FAIL fhold_inst_pc got=%h want=8000_0100", bus.inst_pc); end
    bus.trap_enter     = 1'b1;
    bus.trap_ret       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.mtvec          = 64'h8000_1000;
    bus.mepc           = 64'h8000_2000;
    bus.redirect_pc    = 64'h8000_3000;
    bus.inst_ready     = 1'b1;
    step();
    bus.trap_enter     = 1'b0;
    bus.trap_ret       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL fhold_valid_drop got=%0b want=0", bus.inst_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL fhold_req got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_1000) begin n_err++; $display("FAIL fhold_addr got=%h want=8000_1000", bus.imem_addr); end
    n_cmp++; if (bus.fetch_cnt !== 64'd2) begin n_err++; $display("FAIL fhold_cnt got=%0d want=2", bus.fetch_cnt); end
    $display("flush_hold: trap wins, request 0x%h cnt=%0d", bus.imem_addr, bus.fetch_cnt);
  endtask

  task automatic test_wrap();
    // redirect in FETCH without grant; target low bits must be cleared
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got=%h want=fffffffffffffffc", bus.imem_addr); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_req got=%0b want=1", bus.imem_req); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0001;
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_inst_pc got=%h want=fffffffffffffffc", bus.inst_pc); end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    n_cmp++; if (bus.imem_addr !== 64'h0) begin n_err++; $display("FAIL wrap_next_addr got=%h want=0", bus.imem_addr); end
    n_cmp++; if (bus.fetch_cnt !== 64'd3) begin n_err++; $display("FAIL wrap_cnt got=%0d want=3", bus.fetch_cnt); end
    $display("wrap: pc wrapped to 0x%h cnt=%0d", bus.imem_addr, bus.fetch_cnt);
  endtask

  task automatic test_grant_flush();
    // flush in the same cycle the request is granted
    bus.imem_gnt       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    step();
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b0;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL gflush_noreq got=%0b want=0", bus.imem_req); end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL gflush_valid got=%0b want=0", bus.inst_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL gflush_req got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0200) begin n_err++; $display("FAIL gflush_addr got=%h want=8000_0200", bus.imem_addr); end
    $display("grant_flush: wrong-path grant dropped, request 0x%h", bus.imem_addr);
  endtask

  task automatic test_reset_wait();
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rwait_req got=%0b want=0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL rwait_addr got=%h want=8000_0000", bus.imem_addr); end
    n_cmp++; if (bus.inst !== 32'h0) begin n_err++; $display("FAIL rwait_inst got=%h want=0", bus.inst); end
    n_cmp++; if (bus.inst_pc !== 64'h0) begin n_err++; $display("FAIL rwait_inst_pc got=%h want=0", bus.inst_pc); end
    n_cmp++; if (bus.fetch_cnt !== 64'h0) begin n_err++; $display("FAIL rwait_cnt got=%0d want=0", bus.fetch_cnt); end
    // a late response during reset must be ignored
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hbad0_bad0;
    step();
    bus.imem_rvalid = 1'b0;
    rst = 1'b0;
    step();
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rwait_req_after got=%0b want=1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 64'h8000_0000) begin n_err++; $display("FAIL rwait_addr_after got=%h want=8000_0000", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0011;
    step();
    bus.imem_rvalid = 1'b0;
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL rwait_valid got=%0b want=1", bus.inst_valid); end
    n_cmp++; if (bus.inst !== 32'h0000_0011) begin n_err++; $display("FAIL rwait_inst_after got=%h want=00000011", bus.inst); end
    n_cmp++; if (bus.inst_pc !== 64'h8000_0000) begin n_err++; $display("FAIL rwait_inst_pc_after got=%h want=8000_0000", bus.inst_pc); end
    $display("reset_wait: reset mid-fetch, refetched 0x%h", bus.inst_pc);
  endtask

  initial begin
    n_cmp              = 0;
    n_err              = 0;
    rst                = 1'b1;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.trap_enter     = 1'b0;
    bus.mtvec          = 64'h0;
    bus.trap_ret       = 1'b0;
    bus.mepc           = 64'h0;

    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_flush_hold();
    test_wrap();
    test_grant_flush();
    test_reset_wait();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
